// File: rtl/game_flow_ctrl_if.sv
// rtl/game_flow_ctrl_if.sv - game flow controller event/key inputs and state/pulse outputs
interface game_flow_ctrl_if #(
   parameter int N_CHAR = 3,
   parameter int N_BALL = 4
);
   logic              frame_tick;
   logic [7:0]        keycode;
   logic              exit_hit;
   logic              coin_hit;
   logic              level_end;
   logic              sprite_hit;
   logic              time_up;
   logic              halt_state;
   logic              menu_screen;
   logic              pause_state;
   logic              end_state;
   logic              level_inc;
   logic              score_inc;
   logic              clr;
   logic [N_CHAR-1:0] char_sel;
   logic [N_BALL-1:0] ball_sel;
   logic [3:0]        lives;

   modport master (
      output frame_tick, keycode, exit_hit, coin_hit, level_end, sprite_hit, time_up,
      input  halt_state, menu_screen, pause_state, end_state, level_inc, score_inc, clr,
             char_sel, ball_sel, lives
   );

   modport slave (
      input  frame_tick, keycode, exit_hit, coin_hit, level_end, sprite_hit, time_up,
      output halt_state, menu_screen, pause_state, end_state, level_inc, score_inc, clr,
             char_sel, ball_sel, lives
   );
endinterface

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - single-clock maze game flow FSM with menu, lives, pause and score timing
module game_flow_ctrl #(
   parameter int         N_CHAR        = 3,
   parameter int         N_BALL        = 4,
   parameter int         LIVES         = 3,
   parameter int         SCORE_DELAY   = 3,
   parameter int         HIT_COOLDOWN  = 30,
   parameter logic [7:0] KEY_START     = 8'd44,
   parameter logic [7:0] KEY_MENU      = 8'd16,
   parameter logic [7:0] KEY_CONFIRM   = 8'd40,
   parameter logic [7:0] KEY_RESTART   = 8'd41,
   parameter logic [7:0] KEY_PAUSE     = 8'd19,
   parameter logic [7:0] KEY_CHAR_BASE = 8'd13,
   parameter logic [7:0] KEY_BALL_BASE = 8'd4
) (
   input logic              Clk,
   input logic              Reset_n,
   game_flow_ctrl_if.slave  bus
);
   localparam logic [2:0] S_HALT  = 3'd0;
   localparam logic [2:0] S_MENU  = 3'd1;
   localparam logic [2:0] S_PLAY  = 3'd2;
   localparam logic [2:0] S_PAUSE = 3'd3;
   localparam logic [2:0] S_SCORE = 3'd4;
   localparam logic [2:0] S_LEVEL = 3'd5;
   localparam logic [2:0] S_HIT   = 3'd6;
   localparam logic [2:0] S_DONE  = 3'd7;

   logic [2:0]        state, state_nx;
   logic [7:0]        key_q;
   logic              kp;
   logic              hit_go;
   logic [3:0]        score_cnt;
   logic [7:0]        cool_cnt;
   logic [3:0]        lives_q;
   logic [N_CHAR-1:0] char_q;
   logic [N_BALL-1:0] ball_q;
   logic              halt_q, menu_q, pause_q, end_q, level_q, score_q, clr_q;

   // Only the first cycle of a new non-zero code counts as a press
   assign kp     = (bus.keycode != 8'd0) && (bus.keycode != key_q);
   assign hit_go = (state == S_PLAY) && !bus.exit_hit && !bus.time_up && !bus.coin_hit &&
                   !bus.level_end && bus.sprite_hit;

   always_comb begin
      state_nx = state;
      case (state)
         S_HALT: begin
            if (kp && bus.keycode == KEY_START)     state_nx = S_PLAY;
            else if (kp && bus.keycode == KEY_MENU) state_nx = S_MENU;
         end
         S_MENU:  if (kp && bus.keycode == KEY_CONFIRM) state_nx = S_PLAY;
         S_PLAY: begin
            if (bus.exit_hit || bus.time_up) state_nx = S_DONE;
            else if (bus.coin_hit)           state_nx = S_SCORE;
            else if (bus.level_end)          state_nx = S_LEVEL;
            else if (hit_go)                 state_nx = (lives_q <= 4'd1) ? S_DONE : S_HIT;
            else if (kp && bus.keycode == KEY_PAUSE) state_nx = S_PAUSE;
         end
         S_PAUSE: if (kp && bus.keycode == KEY_PAUSE) state_nx = S_PLAY;
         S_SCORE: if (score_cnt <= 4'd1) state_nx = S_PLAY;
         S_LEVEL: state_nx = S_PLAY;
         S_HIT:   if (cool_cnt == 8'd0) state_nx = S_PLAY;
         S_DONE:  if (kp && bus.keycode == KEY_RESTART) state_nx = S_HALT;
         default: state_nx = S_HALT;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state     <= S_HALT;
         key_q     <= 8'd0;
         score_cnt <= 4'd0;
         cool_cnt  <= 8'd0;
         lives_q   <= 4'(LIVES);
         char_q    <= '0;
         ball_q    <= '0;
         halt_q    <= 1'b1;
         menu_q    <= 1'b0;
         pause_q   <= 1'b0;
         end_q     <= 1'b0;
         level_q   <= 1'b0;
         score_q   <= 1'b0;
         clr_q     <= 1'b0;
      end else begin
         state   <= state_nx;
         key_q   <= bus.keycode;
         halt_q  <= (state == S_HALT);
         menu_q  <= (state == S_MENU);
         pause_q <= (state == S_PAUSE);
         end_q   <= (state == S_DONE);
         level_q <= (state == S_LEVEL);
         score_q <= (state == S_SCORE) && (score_cnt == 4'd1);
         clr_q   <= (state == S_HALT) && (state_nx != S_HALT);

         if (state != S_SCORE && state_nx == S_SCORE)  score_cnt <= 4'(SCORE_DELAY);
         else if (state == S_SCORE && score_cnt != 4'd0) score_cnt <= score_cnt - 4'd1;

         // The entry edge loads the cooldown, so a coincident frame_tick is not counted
         if (state != S_HIT && state_nx == S_HIT) cool_cnt <= 8'(HIT_COOLDOWN);
         else if (state == S_HIT && bus.frame_tick && cool_cnt != 8'd0) cool_cnt <= cool_cnt - 8'd1;

         if (state == S_HALT && state_nx != S_HALT) lives_q <= 4'(LIVES);
         else if (hit_go) lives_q <= (lives_q > 4'd1) ? lives_q - 4'd1 : 4'd0;

         if (state != S_MENU && state_nx == S_MENU) begin
            ball_q <= '0;
         end else if (state == S_MENU && kp) begin
            for (int i = 0; i < N_CHAR; i++)
               if (bus.keycode == KEY_CHAR_BASE + 8'(i)) char_q <= N_CHAR'(1) << i;
            for (int j = 0; j < N_BALL; j++)
               if (bus.keycode == KEY_BALL_BASE + 8'(j)) ball_q <= N_BALL'(1) << j;
         end
      end
   end

   assign bus.halt_state  = halt_q;
   assign bus.menu_screen = menu_q;
   assign bus.pause_state = pause_q;
   assign bus.end_state   = end_q;
   assign bus.level_inc   = level_q;
   assign bus.score_inc   = score_q;
   assign bus.clr         = clr_q;
   assign bus.char_sel    = char_q;
   assign bus.ball_sel    = ball_q;
   assign bus.lives       = lives_q;
endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - directed bench with pulse scoreboard for game_flow_ctrl
module tb_game_flow_ctrl;
   localparam int SCORE_DELAY = 3;

   logic Clk = 1'b0;
   logic Reset_n;
   int   cyc = 0;
   int   n_pass = 0;
   int   n_total = 0;
   int   n_fail = 0;
   int   q_score[$];
   int   q_level[$];
   int   q_clr[$];

   game_flow_ctrl_if #(.N_CHAR(3), .N_BALL(4)) bus ();

   game_flow_ctrl #(
      .N_CHAR(3), .N_BALL(4), .LIVES(3), .SCORE_DELAY(SCORE_DELAY), .HIT_COOLDOWN(2)
   ) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(negedge Clk);
      bus.frame_tick = (cyc % 4 == 0);
   endtask

   task automatic key(logic [7:0] k);
      bus.keycode = k;
      nxt();
      bus.keycode = 8'd0;
      nxt();
   endtask

   // Pulses are compared against the cycle numbers queued when the stimulus was driven
   always @(negedge Clk) begin
      if (Reset_n) begin
         bit e;
         e = (q_score.size() > 0 && q_score[0] == cyc);
         if (e) void'(q_score.pop_front());
         if (e || bus.score_inc !== 1'b0) chk("score_inc", 32'(bus.score_inc), 32'(e));
         e = (q_level.size() > 0 && q_level[0] == cyc);
         if (e) void'(q_level.pop_front());
         if (e || bus.level_inc !== 1'b0) chk("level_inc", 32'(bus.level_inc), 32'(e));
         e = (q_clr.size() > 0 && q_clr[0] == cyc);
         if (e) void'(q_clr.pop_front());
         if (e || bus.clr !== 1'b0) chk("clr", 32'(bus.clr), 32'(e));
      end
   end

   initial begin
      Reset_n = 1'b0;
      bus.frame_tick = 1'b0; bus.keycode = 8'd0; bus.exit_hit = 1'b0; bus.coin_hit = 1'b0;
      bus.level_end = 1'b0; bus.sprite_hit = 1'b0; bus.time_up = 1'b0;
      repeat (3) nxt();
      chk("rst_halt", bus.halt_state, 1);
      chk("rst_flags", {bus.menu_screen, bus.pause_state, bus.end_state}, 0);
      chk("rst_sel", {bus.char_sel, bus.ball_sel}, 0);
      chk("rst_lives", bus.lives, 3);
      Reset_n = 1'b1;
      nxt();

      // Start key held for 10 cycles gives one transition and one clr
      q_clr.push_back(cyc + 1);
      bus.keycode = 8'd44;
      repeat (10) nxt();
      bus.keycode = 8'd0;
      chk("start_halt", bus.halt_state, 0);
      chk("start_lives", bus.lives, 3);
      chk("start_flags", {bus.menu_screen, bus.pause_state, bus.end_state}, 0);

      // exit_hit and coin_hit together: DONE wins, no score_inc
      bus.exit_hit = 1'b1; bus.coin_hit = 1'b1;
      nxt();
      bus.exit_hit = 1'b0; bus.coin_hit = 1'b0;
      nxt();
      chk("prio_end", bus.end_state, 1);
      key(8'd41);
      chk("restart_halt", bus.halt_state, 1);
      chk("restart_end", bus.end_state, 0);

      q_clr.push_back(cyc + 1);
      key(8'd16);
      chk("menu_flag", bus.menu_screen, 1);
      chk("menu_ball0", bus.ball_sel, 0);
      key(8'd14);
      chk("menu_char", bus.char_sel, 3'b010);
      key(8'd5);
      chk("menu_ball", bus.ball_sel, 4'b0010);
      key(8'd40);
      chk("confirm_menu", bus.menu_screen, 0);
      chk("confirm_halt", bus.halt_state, 0);

      bus.time_up = 1'b1;
      nxt();
      bus.time_up = 1'b0;
      nxt();
      chk("timeup_end", bus.end_state, 1);
      chk("done_keep_sel", {bus.char_sel, bus.ball_sel}, {3'b010, 4'b0010});
      key(8'd41);
      q_clr.push_back(cyc + 1);
      key(8'd16);
      chk("reenter_menu", bus.menu_screen, 1);
      chk("reenter_sel", {bus.char_sel, bus.ball_sel}, {3'b010, 4'b0000});
      key(8'd40);

      // Score latency; a second coin during SCORE is dropped
      q_score.push_back(cyc + 1 + SCORE_DELAY);
      bus.coin_hit = 1'b1;
      nxt();
      bus.coin_hit = 1'b0;
      nxt();
      bus.coin_hit = 1'b1;
      nxt();
      bus.coin_hit = 1'b0;
      repeat (4) nxt();
      q_level.push_back(cyc + 2);
      bus.level_end = 1'b1;
      nxt();
      bus.level_end = 1'b0;
      repeat (3) nxt();

      key(8'd19);
      chk("pause_on", bus.pause_state, 1);
      bus.coin_hit = 1'b1;
      nxt();
      bus.coin_hit = 1'b0; bus.exit_hit = 1'b1;
      nxt();
      bus.exit_hit = 1'b0;
      repeat (2) nxt();
      chk("pause_hold", bus.pause_state, 1);
      chk("pause_noend", bus.end_state, 0);
      key(8'd19);
      chk("pause_off", bus.pause_state, 0);
      chk("pause_off_end", bus.end_state, 0);

      // Hits: the one during cooldown must not cost a life
      bus.sprite_hit = 1'b1;
      nxt();
      bus.sprite_hit = 1'b0;
      nxt();
      chk("hit1_lives", bus.lives, 2);
      bus.sprite_hit = 1'b1;
      nxt();
      bus.sprite_hit = 1'b0;
      nxt();
      chk("cool_lives", bus.lives, 2);
      repeat (16) nxt();
      bus.sprite_hit = 1'b1;
      nxt();
      bus.sprite_hit = 1'b0;
      nxt();
      chk("hit2_lives", bus.lives, 1);
      chk("hit2_end", bus.end_state, 0);
      repeat (16) nxt();
      bus.sprite_hit = 1'b1;
      nxt();
      bus.sprite_hit = 1'b0;
      nxt();
      chk("hit3_lives", bus.lives, 0);
      chk("hit3_end", bus.end_state, 1);
      key(8'd41);
      chk("hit3_restart", bus.halt_state, 1);

      // Reset asserted mid-SCORE: immediate reset values, no late score_inc
      q_clr.push_back(cyc + 1);
      key(8'd44);
      bus.coin_hit = 1'b1;
      nxt();
      bus.coin_hit = 1'b0;
      Reset_n = 1'b0;
      #1;
      chk("async_halt", bus.halt_state, 1);
      chk("async_score", bus.score_inc, 0);
      chk("async_lives", bus.lives, 3);
      repeat (3) nxt();
      Reset_n = 1'b1;
      repeat (8) nxt();
      chk("post_rst_halt", bus.halt_state, 1);

      chk("sb_score_empty", q_score.size(), 0);
      chk("sb_level_empty", q_level.size(), 0);
      chk("sb_clr_empty", q_clr.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
